// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Loads a program image into program memory from a byte-wide stream and
// keeps the processor in reset until a complete, checksum-verified image has
// been written.
//
// Stream frame: 0xA5, LEN_H, LEN_L, LEN payload bytes, CSUM
//   LEN  : 16-bit big-endian byte count, legal range 1..2^N
//   CSUM : 8-bit sum of the payload bytes, mod 256
//
// Parameters:
//   N : program memory address width (image capacity is 2^N bytes, N <= 15)
//   M : program memory word width (must be 8, one stream byte per word)
//
// Ports:
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   in_data   : stream byte
//   in_valid  : in_data valid this cycle
//   in_ready  : loader accepts a byte this cycle (always 1 out of reset)
//   mem_we    : program memory write enable, one-cycle pulse
//   mem_addr  : program memory write address
//   mem_wdata : program memory write data
//   cpu_hold  : keeps the processor in reset while high
//   done      : a valid image has been loaded
//   err       : last load attempt failed
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int N = 12,
  parameter int M = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [7:0]  SYNC     = 8'hA5;
  // Capacity as a 17-bit value so it can be compared against the full
  // 16-bit LEN field without truncation, including LEN = 2^N itself.
  localparam logic [16:0] CAPACITY = 17'(2 ** N);
  localparam logic [N:0]  ONE      = (N + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  logic [7:0] len_hi;
  // Length and counter are N+1 bits so a full 2^N image is representable
  // and the write address never wraps.
  logic [N:0] len;
  logic [N:0] count;
  logic [7:0] sum;

  logic [15:0] len_full;
  logic [N:0]  count_next;
  logic        len_bad;

  assign len_full   = {len_hi, in_data};
  assign count_next = count + ONE;
  assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > CAPACITY);

  // Frame parser. Every output is a register updated together with the
  // state transition that implies it, so done/err/cpu_hold always reflect
  // the state entered on the previous edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      len       <= '0;
      count     <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (in_valid) begin
        case (state)
          S_IDLE: begin
            if (in_data == SYNC) begin
              state <= S_LEN_H;
            end
          end
          S_LEN_H: begin
            len_hi <= in_data;
            state  <= S_LEN_L;
          end
          S_LEN_L: begin
            if (len_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              len   <= len_full[N:0];
              count <= '0;
              sum   <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            // 0xA5 here is ordinary payload; only the count ends the data.
            mem_we    <= 1'b1;
            mem_addr  <= count[N-1:0];
            mem_wdata <= M'(in_data);
            sum       <= sum + in_data;
            count     <= count_next;
            if (count_next == len) begin
              state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (in_data == sum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          S_DONE, S_ERR: begin
            // A new sync restarts the load and puts the processor back
            // into reset before any memory write can happen.
            if (in_data == SYNC) begin
              state    <= S_LEN_H;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
